// File: rtl/aes_pkg.sv
// Shared AES definitions: round/word counts, the rcon start value, GF(2^8) doubling
// and the key-schedule FSM state encoding.
package aes_pkg;

  localparam int         AES_NR       = 10;
  localparam int         AES_NK       = 4;
  localparam logic [7:0] AES_RCON_RST = 8'h01;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_EXPAND,
    KS_READY
  } ks_state_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One combinational AES-128 key-schedule step: derives round key r+1 from round key r
// and the round constant. Word 0 sits in [127:96].
module aes_key_step (
  input  logic [127:0] in,
  input  logic [7:0]   rcon,
  output logic [127:0] out
);

  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;

  // RotWord of the last word: {b1,b2,b3,b0}.
  assign w_rot = {in[23:0], in[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .i_byte(w_rot[8*b +: 8]),
      .o_byte(w_sub[8*b +: 8])
    );
  end

  assign w_w0 = in[127:96] ^ w_sub ^ {rcon, 24'h0};
  assign w_w1 = in[95:64]  ^ w_w0;
  assign w_w2 = in[63:32]  ^ w_w1;
  assign w_w3 = in[31:0]   ^ w_w2;
  assign out  = {w_w0, w_w1, w_w2, w_w3};

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box as a 256-entry constant table; the same cell is used by SubBytes
// in the round datapath and by SubWord in the key schedule.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: expands one round key per cycle into an 11-entry
// register file and serves keys by round index in encrypt or decrypt order.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter bit RD_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         keys_ok,
  output logic         busy,
  input  logic [3:0]   rd_idx,
  input  logic         rd_dec,
  output logic [127:0] rd_key
);

  localparam logic [3:0] NR_W = 4'(NR);

  ks_state_e    r_state;
  ks_state_e    w_state_nxt;
  logic [127:0] r_keys [NR+1];
  logic [3:0]   r_cnt;
  logic [7:0]   r_rcon;
  logic         w_hs;
  logic [127:0] w_prev;
  logic [127:0] w_step;
  logic [3:0]   w_eff;
  logic [127:0] w_rd_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= KS_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    busy        = 1'b0;
    key_ready   = 1'b1;
    keys_ok     = 1'b0;
    unique case (r_state)
      KS_IDLE, KS_READY: begin
        keys_ok = (r_state == KS_READY);
        w_hs    = key_valid;
        if (key_valid) w_state_nxt = KS_EXPAND;
      end
      KS_EXPAND: begin
        busy      = 1'b1;
        key_ready = 1'b0;
        if (r_cnt == NR_W) w_state_nxt = KS_READY;
      end
      default: w_state_nxt = KS_IDLE;
    endcase
  end

  always_comb begin
    w_prev = '0;
    if (r_cnt != 4'd0) w_prev = r_keys[r_cnt - 4'd1];
  end

  aes_key_step u_step (
    .in  (w_prev),
    .rcon(r_rcon),
    .out (w_step)
  );

  // NOTE: the key file is reset explicitly: an abort mid-expansion must not leave
  // partial keys readable, so this array cannot be mapped onto an unreset RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) r_keys[i] <= '0;
      r_cnt  <= '0;
      r_rcon <= AES_RCON_RST;
    end else if (w_hs) begin
      // NOTE: state updates use <= so every register samples pre-edge values.
      r_keys[0] <= key_in;
      r_cnt     <= 4'd1;
      r_rcon    <= AES_RCON_RST;
    end else if (busy) begin
      r_keys[r_cnt] <= w_step;
      r_cnt         <= r_cnt + 4'd1;
      r_rcon        <= xtime(r_rcon);
    end
  end

  // Out-of-range indices read as zero rather than wrapping into the file.
  always_comb begin
    w_eff    = rd_dec ? (NR_W - rd_idx) : rd_idx;
    w_rd_mux = '0;
    if (rd_idx <= NR_W) w_rd_mux = r_keys[w_eff];
  end

  if (RD_REG) begin : g_rd_reg
    logic [127:0] r_rd_key;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rd_key <= '0;
      else        r_rd_key <= w_rd_mux;
    end
    assign rd_key = r_rd_key;
  end else begin : g_rd_comb
    assign rd_key = w_rd_mux;
  end

endmodule
